// File: rtl/ram_burst_pkg.sv
// Shared definitions for the RAM burst master and its read-side buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_burst_pkg;

    localparam int DW_DEF       = 32;  // default data width, matches RAM data/q
    localparam int AW_DEF       = 12;  // default address width, RAM depth 2**AW
    localparam int READ_LAT     = 1;   // RAM q follows addr by one cycle
    localparam int RD_BUF_DEPTH = 2;   // read-return buffer entries

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/ram_rd_skid.sv
// Two-entry valid/ready buffer catching RAM read data, exposes occupancy for issue credit.
// Latency: word pushed at an edge is visible on q_vld/q_dat the following cycle.
// Backpressure: q_dat holds while q_vld && !q_rdy; the producer must never push into a full buffer.
module ram_rd_skid #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_vld,
    input  logic [DW-1:0] push_dat,
    output logic          q_vld,
    output logic [DW-1:0] q_dat,
    input  logic          q_rdy,
    output logic [1:0]    occ
);

    logic [DW-1:0] mem [2];
    logic          wptr;
    logic          rptr;
    logic [1:0]    cnt;
    logic          pop;

    assign q_vld = (cnt != 2'd0);
    assign q_dat = mem[rptr];
    assign pop   = q_vld && q_rdy;
    assign occ   = cnt;

    // storage, pointers and count; cleared on reset so q_dat reads zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push_vld) begin
                mem[wptr] <= push_dat;
                wptr      <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            cnt <= cnt + {1'b0, push_vld} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for single_port_ram: one command becomes consecutive RAM writes or reads.
// Latency: writes 1 word/cycle; reads deliver first word 2 cycles after accept, then 1 word/cycle.
// Backpressure: wr stream stalls via wr_valid; rd_ready low throttles RAM issue by buffer credit.
// Optional running transfer checksum port xfer_sum when RAM_XFER_SUM_EN is defined.
module ram_burst_master
    import ram_burst_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW:0]   cmd_len,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] ram_data,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q
`ifdef RAM_XFER_SUM_EN
    ,
    output logic [DW-1:0] xfer_sum
`endif
);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] cur;
    logic [AW-1:0] addr_hold;
    logic [AW:0]   remaining;
    logic          inflight;
    logic          accept;
    logic          wr_fire;
    logic          rd_issue;
    logic          rd_pop;
    logic          credit;
    logic          last_word;
    logic [1:0]    occ;

    assign accept    = cmd_valid && cmd_ready;
    assign wr_fire   = (state == ST_WRITE) && wr_valid;
    assign rd_pop    = rd_valid && rd_ready;
    assign last_word = (remaining == (AW+1)'(1));
    // A word leaving the buffer this cycle frees its slot before a word issued now can land,
    // so count it as free; this is what sustains 1 word/cycle with rd_ready held high.
    assign credit    = ({1'b0, occ} + {2'b0, inflight}) < (3'(RD_BUF_DEPTH) + {2'b0, rd_pop});
    assign rd_issue  = (state == ST_READ) && credit;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state: burst sequencing
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_len == '0) begin
                        state_nxt = ST_DONE;
                    end else if (cmd_write) begin
                        state_nxt = ST_WRITE;
                    end else begin
                        state_nxt = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                if (wr_fire && last_word) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_READ: begin
                if (rd_issue && last_word) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!inflight && (occ == 2'd0)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // outputs: handshakes, status and RAM port; cmd_ready is masked while reset is held
    always_comb begin
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        done      = 1'b0;
        busy      = (state != ST_IDLE);
        ram_we    = wr_fire;
        ram_data  = wr_fire ? wr_data : '0;
        ram_addr  = (wr_fire || rd_issue) ? cur : addr_hold;
        case (state)
            ST_IDLE:  cmd_ready = rst_n;
            ST_WRITE: wr_ready  = 1'b1;
            ST_DONE:  done      = 1'b1;
            default:  ;
        endcase
    end

    // burst address/count tracking, read in-flight flag and last presented address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            addr_hold <= '0;
        end else begin
            inflight <= rd_issue;
            if (accept) begin
                cur       <= cmd_addr;
                remaining <= cmd_len;
            end else if (wr_fire || rd_issue) begin
                cur       <= cur + AW'(1);
                remaining <= remaining - (AW+1)'(1);
                addr_hold <= cur;
            end
        end
    end

    ram_rd_skid #(
        .DW (DW)
    ) u_rd_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (inflight),
        .push_dat (ram_q),
        .q_vld    (rd_valid),
        .q_dat    (rd_data),
        .q_rdy    (rd_ready),
        .occ      (occ)
    );

`ifdef RAM_XFER_SUM_EN
    // running sum of every word written or delivered, restarted on each accepted command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_sum <= '0;
        end else if (accept) begin
            xfer_sum <= '0;
        end else if (wr_fire) begin
            xfer_sum <= xfer_sum + wr_data;
        end else if (rd_pop) begin
            xfer_sum <= xfer_sum + rd_data;
        end
    end
`endif

endmodule

// File: tb/tb_ram_burst_master.sv
// Randomized scoreboard bench for ram_burst_master with a behavioural RAM and reference memory.
// Latency: n/a.
// Backpressure: rd_ready patterns (held, 1-0-0, random, stalled) and random write-stream gaps.
module tb_ram_burst_master;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int DEPTH = 4096;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_len;
    logic [DW-1:0] wr_data;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_ready;
    logic          busy, done;
    logic [DW-1:0] ram_data;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_q;
`ifdef RAM_XFER_SUM_EN
    logic [DW-1:0] xfer_sum;
`endif

    ram_burst_master #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .busy      (busy),
        .done      (done),
        .ram_data  (ram_data),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_q     (ram_q)
`ifdef RAM_XFER_SUM_EN
        ,
        .xfer_sum  (xfer_sum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rdy_mode = 0;
    int rdy_phase = 0;

    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic          mem_init = 1'b0;

    wr_t           wq[$];
    logic [DW-1:0] rq[$];
    int            rd_hs[$];
    int            we_cyc[$];
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_dat = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not allowed here (cycle %0d)", name, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // behavioural single-port RAM: write on we, q is the addressed word one cycle later
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= '0;
            mem_init <= 1'b1;
        end else if (ram_we) begin
            ram_mem[ram_addr] <= ram_data;
        end
        ram_q <= ram_mem[ram_addr];
    end

    // read-stream consumer
    initial begin
        rd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: rd_ready = 1'b1;
                1: begin rd_ready = (rdy_phase % 3 == 0); rdy_phase++; end
                2: rd_ready = 1'($urandom_range(0, 1));
                default: rd_ready = 1'b0;
            endcase
        end
    end

    // monitor: compares RAM writes and delivered read words against the scoreboard queues
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev <= 1'b0;
        end else begin
            if (ram_we) begin
                if (wq.size() == 0) begin
                    fail_evt("unexpected_ram_write");
                end else begin
                    chk("wr_addr", 64'(ram_addr), 64'(wq[0].a));
                    chk("wr_data", 64'(ram_data), 64'(wq[0].d));
                    void'(wq.pop_front());
                end
                we_cyc.push_back(cyc);
            end
            if (stall_prev) begin
                chk("rd_valid_held", 64'(rd_valid), 64'(1));
                chk("rd_data_stable", 64'(rd_data), 64'(stall_dat));
            end
            if (rd_valid && rd_ready) begin
                if (rq.size() == 0) begin
                    fail_evt("unexpected_rd_word");
                end else begin
                    chk("rd_data", 64'(rd_data), 64'(rq[0]));
                    void'(rq.pop_front());
                end
                rd_hs.push_back(cyc);
            end
            stall_prev <= rd_valid && !rd_ready;
            stall_dat  <= rd_data;
        end
    end

    task automatic cmd(input bit w, input int addr, input int len);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = AW'(addr);
        cmd_len   = (AW+1)'(len);
        while (n < 50 && !ok) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                acc_cyc = cyc + 1;
            end
            n++;
        end
        if (!ok) fail_evt("cmd_accept_timeout");
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int dc);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        dc   = -1;
        while (n < 300 && !seen) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                dc   = cyc;
            end
            n++;
        end
        if (!seen) begin
            fail_evt(tag);
        end else begin
            @(negedge clk);
            chk("done_one_cycle", 64'(done), 64'(0));
            chk("busy_after_done", 64'(busy), 64'(0));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int addr, input int len, input bit seq, input bit gaps, input bit tim);
        logic [DW-1:0] dats[$];
        int            a, n, dc;
        bit            ok;
        for (int i = 0; i < len; i++) begin
            a = (addr + i) % DEPTH;
            dats.push_back(seq ? DW'(i + 1) : DW'($urandom));
            wq.push_back('{a: AW'(a), d: dats[i]});
            ref_mem[a] = dats[i];
        end
        we_cyc.delete();
        cmd(1'b1, addr, len);
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                wr_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            wr_valid = 1'b1;
            wr_data  = dats[i];
            n  = 0;
            ok = 1'b0;
            while (n < 50 && !ok) begin
                @(negedge clk);
                ok = wr_ready;
                @(posedge clk);
                #1;
                n++;
            end
            if (!ok) fail_evt("wr_ready_timeout");
        end
        wr_valid = 1'b0;
        wait_done("write_done_timeout", dc);
        if (tim) begin
            chk("we_count", 64'(we_cyc.size()), 64'(len));
            if (len == 0) begin
                chk("len0_done_cycle", 64'(dc), 64'(acc_cyc));
            end else if (we_cyc.size() == len) begin
                chk("first_we_cycle", 64'(we_cyc[0]), 64'(acc_cyc));
                chk("done_after_last_we", 64'(dc), 64'(we_cyc[len-1] + 1));
            end
        end
    endtask

    task automatic do_read(input int addr, input int len, input bit tim);
        int dc;
        for (int i = 0; i < len; i++) rq.push_back(ref_mem[(addr + i) % DEPTH]);
        rd_hs.delete();
        cmd(1'b0, addr, len);
        wait_done("read_done_timeout", dc);
        chk("rd_all_delivered", 64'(rq.size()), 64'(0));
        rq.delete();
        if (tim) begin
            chk("rd_word_count", 64'(rd_hs.size()), 64'(len));
            if (len == 0) begin
                chk("len0_done_cycle", 64'(dc), 64'(acc_cyc));
            end else if (rd_hs.size() == len) begin
                chk("first_rd_cycle", 64'(rd_hs[0]), 64'(acc_cyc + 2));
                for (int i = 1; i < len; i++)
                    chk("rd_back_to_back", 64'(rd_hs[i]), 64'(rd_hs[i-1] + 1));
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(0));
        chk({tag, "_wr_ready"},  64'(wr_ready),  64'(0));
        chk({tag, "_rd_valid"},  64'(rd_valid),  64'(0));
        chk({tag, "_rd_data"},   64'(rd_data),   64'(0));
        chk({tag, "_busy"},      64'(busy),      64'(0));
        chk({tag, "_done"},      64'(done),      64'(0));
        chk({tag, "_ram_we"},    64'(ram_we),    64'(0));
        chk({tag, "_ram_addr"},  64'(ram_addr),  64'(0));
        chk({tag, "_ram_data"},  64'(ram_data),  64'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int last_waddr;
        int a, l;
        bit w;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_data   = '0;
        wr_valid  = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("idle_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;

        // three-word write then read-back with rd_ready held high
        rdy_mode = 0;
        do_write(0, 3, 1'b1, 1'b0, 1'b1);
`ifdef RAM_XFER_SUM_EN
        chk("xfer_sum_write", 64'(xfer_sum), 64'h6);
`endif
        do_read(0, 3, 1'b1);
`ifdef RAM_XFER_SUM_EN
        chk("xfer_sum_read", 64'(xfer_sum), 64'h6);
`endif

        // read under 1,0,0 ready pattern
        do_write(16, 4, 1'b0, 1'b0, 1'b1);
        rdy_mode  = 1;
        rdy_phase = 0;
        do_read(16, 4, 1'b0);
        rdy_mode = 0;

        // address wrap
        do_write(4095, 2, 1'b0, 1'b0, 1'b1);
        do_read(4095, 2, 1'b1);

        // zero-length commands
        do_write(100, 0, 1'b0, 1'b0, 1'b1);
        do_read(100, 0, 1'b1);

        // reset in the middle of a stalled read burst
        do_write(200, 8, 1'b0, 1'b0, 1'b0);
        rdy_mode = 3;
        cmd(1'b0, 200, 8);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (2) begin
            @(negedge clk);
            chk("midreset_no_done", 64'(done), 64'(0));
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy_mode = 0;
        do_read(200, 8, 1'b1);
        do_write(300, 5, 1'b0, 1'b0, 1'b1);

        // randomized mixed traffic
        last_waddr = 300;
        for (int it = 0; it < 40; it++) begin
            w = 1'($urandom_range(0, 1));
            l = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) a = DEPTH - $urandom_range(1, 4);
            else a = $urandom_range(0, DEPTH - 1);
            rdy_mode  = $urandom_range(1, 2);
            rdy_phase = 0;
            if (w) begin
                do_write(a, l, 1'b0, 1'b1, 1'b0);
                last_waddr = a;
            end else begin
                do_read(($urandom_range(0, 1) == 1) ? last_waddr : a, l, 1'b0);
            end
        end
        rdy_mode = 0;

        repeat (4) @(posedge clk);
        chk("wq_empty_at_end", 64'(wq.size()), 64'(0));
        chk("rq_empty_at_end", 64'(rq.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
